// File: rtl/e203_exu_wbck_sched_if.sv
`default_nettype none
//==============================================================================
// Module      : e203_exu_wbck_sched_if
// Description : Bundle of the write-back scheduler's handshake and bus signals.
//               Carries the stall input, the ALU and long-pipe write-back
//               request channels, the registered regfile write port and, when
//               E203_WBCK_SCHED_PERF_EN is defined, the perf counter signals.
//   Modports  : slave  - the scheduler (consumes requests, drives grants and
//                        the regfile write port)
//               master - the environment (drives requests, observes grants)
//   Signals   : sched_stall_i                      freeze, no grants while high
//               alu_wbck_i_{valid,ready,wdat,rdidx}    ALU write-back channel
//               longp_wbck_i_{valid,ready,wdat,rdidx}  long-pipe write-back channel
//               rf_wbck_o_{ena,wdat,rdidx}             regfile write port
//               perf_clr_i, perf_conflict_o, perf_starv_o  (perf build only)
// Macro       : E203_WBCK_SCHED_PERF_EN - adds the perf counter signals
// Revision    : 1.0 - initial release
//==============================================================================
interface e203_exu_wbck_sched_if #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
`ifdef E203_WBCK_SCHED_PERF_EN
   ,
   parameter int PERF_W  = 16
`endif
);

   logic               sched_stall_i;

   logic               alu_wbck_i_valid;
   logic               alu_wbck_i_ready;
   logic [XLEN-1:0]    alu_wbck_i_wdat;
   logic [RFIDX_W-1:0] alu_wbck_i_rdidx;

   logic               longp_wbck_i_valid;
   logic               longp_wbck_i_ready;
   logic [XLEN-1:0]    longp_wbck_i_wdat;
   logic [RFIDX_W-1:0] longp_wbck_i_rdidx;

   logic               rf_wbck_o_ena;
   logic [XLEN-1:0]    rf_wbck_o_wdat;
   logic [RFIDX_W-1:0] rf_wbck_o_rdidx;

`ifdef E203_WBCK_SCHED_PERF_EN
   logic               perf_clr_i;
   logic [PERF_W-1:0]  perf_conflict_o;
   logic [PERF_W-1:0]  perf_starv_o;

   modport slave (
      input  sched_stall_i,
      input  alu_wbck_i_valid,   output alu_wbck_i_ready,
      input  alu_wbck_i_wdat,    input  alu_wbck_i_rdidx,
      input  longp_wbck_i_valid, output longp_wbck_i_ready,
      input  longp_wbck_i_wdat,  input  longp_wbck_i_rdidx,
      output rf_wbck_o_ena,      output rf_wbck_o_wdat,     output rf_wbck_o_rdidx,
      input  perf_clr_i,         output perf_conflict_o,    output perf_starv_o
   );

   modport master (
      output sched_stall_i,
      output alu_wbck_i_valid,   input  alu_wbck_i_ready,
      output alu_wbck_i_wdat,    output alu_wbck_i_rdidx,
      output longp_wbck_i_valid, input  longp_wbck_i_ready,
      output longp_wbck_i_wdat,  output longp_wbck_i_rdidx,
      input  rf_wbck_o_ena,      input  rf_wbck_o_wdat,     input  rf_wbck_o_rdidx,
      output perf_clr_i,         input  perf_conflict_o,    input  perf_starv_o
   );
`else
   modport slave (
      input  sched_stall_i,
      input  alu_wbck_i_valid,   output alu_wbck_i_ready,
      input  alu_wbck_i_wdat,    input  alu_wbck_i_rdidx,
      input  longp_wbck_i_valid, output longp_wbck_i_ready,
      input  longp_wbck_i_wdat,  input  longp_wbck_i_rdidx,
      output rf_wbck_o_ena,      output rf_wbck_o_wdat,     output rf_wbck_o_rdidx
   );

   modport master (
      output sched_stall_i,
      output alu_wbck_i_valid,   input  alu_wbck_i_ready,
      output alu_wbck_i_wdat,    output alu_wbck_i_rdidx,
      output longp_wbck_i_valid, input  longp_wbck_i_ready,
      output longp_wbck_i_wdat,  output longp_wbck_i_rdidx,
      input  rf_wbck_o_ena,      input  rf_wbck_o_wdat,     input  rf_wbck_o_rdidx
   );
`endif

endinterface : e203_exu_wbck_sched_if
`default_nettype wire

// File: rtl/e203_exu_wbck_sched.sv
`default_nettype none
//==============================================================================
// Module      : e203_exu_wbck_sched
// Description : Schedules the single integer regfile write port between the
//               short-pipe ALU write-back and the arbitrated long-pipe
//               write-back. The long pipe wins by default because it retires
//               OITF entries in order; a starvation counter forces one ALU
//               grant after STARV_MAX consecutive lost cycles. The granted
//               result is registered once and drives the regfile write port.
//   Ports     : clk   - clock
//               rst   - asynchronous active-high reset
//               wbck  - e203_exu_wbck_sched_if.slave (stall, ALU and long-pipe
//                       request channels, regfile write port, perf signals)
//   Params    : XLEN, RFIDX_W, STARV_MAX (1..2**CNT_W-1), CNT_W, PERF_W
// Macro       : E203_WBCK_SCHED_PERF_EN - enables the saturating conflict and
//               forced-grant perf counters with synchronous clear
// Revision    : 1.0 - initial release
//==============================================================================
module e203_exu_wbck_sched #(
   parameter int XLEN      = 32,
   parameter int RFIDX_W   = 5,
   parameter int STARV_MAX = 4,
   parameter int CNT_W     = 3
`ifdef E203_WBCK_SCHED_PERF_EN
   ,
   parameter int PERF_W    = 16
`endif
) (
   input  wire logic                  clk,
   input  wire logic                  rst,
   e203_exu_wbck_sched_if.slave       wbck
);

   localparam logic [CNT_W-1:0]   STARV_LIM = CNT_W'(STARV_MAX);
   localparam logic [RFIDX_W-1:0] IDX_ZERO  = '0;

   // Arbitration priority: long pipe by default, ALU only for one forced slot.
   typedef enum logic [0:0] {
      PRI_LONGP = 1'b0,
      PRI_ALU   = 1'b1
   } pri_t;

   pri_t               pri;
   logic [CNT_W-1:0]   starv_cnt;

   logic               rf_ena;
   logic [XLEN-1:0]    rf_wdat;
   logic [RFIDX_W-1:0] rf_rdidx;

   logic               stall;
   logic               alu_valid;
   logic               longp_valid;
   logic               alu_ready;
   logic               longp_ready;
   logic               alu_fire;
   logic               longp_fire;
   logic               any_fire;
   logic [XLEN-1:0]    sel_wdat;
   logic [RFIDX_W-1:0] sel_rdidx;
   logic               starv_hit;

   assign stall       = wbck.sched_stall_i;
   assign alu_valid   = wbck.alu_wbck_i_valid;
   assign longp_valid = wbck.longp_wbck_i_valid;

   //---------------------------------------------------------------------------
   // Grants. Each ready looks only at the *other* requester's valid, so a
   // requester can see its grant before it asserts valid, and the two readies
   // are never both high while both valids are high: one fire per cycle.
   //---------------------------------------------------------------------------
   assign longp_ready = ~stall & ((pri == PRI_LONGP) | ~alu_valid);
   assign alu_ready   = ~stall & ((pri == PRI_ALU)   | ~longp_valid);

   assign alu_fire    = alu_valid   & alu_ready;
   assign longp_fire  = longp_valid & longp_ready;
   assign any_fire    = alu_fire | longp_fire;

   // Only one side can fire, so a plain two-way select is enough.
   assign sel_wdat    = longp_fire ? wbck.longp_wbck_i_wdat  : wbck.alu_wbck_i_wdat;
   assign sel_rdidx   = longp_fire ? wbck.longp_wbck_i_rdidx : wbck.alu_wbck_i_rdidx;

   // The ALU has lost STARV_MAX cycles in a row and is still waiting.
   assign starv_hit   = alu_valid & (starv_cnt == STARV_LIM);

   assign wbck.alu_wbck_i_ready   = alu_ready;
   assign wbck.longp_wbck_i_ready = longp_ready;

   //---------------------------------------------------------------------------
   // Priority FSM and starvation counter. Everything freezes during stall.
   // The counter counts consecutive cycles in which the ALU was valid but
   // refused; dropping valid or winning a grant restarts the count.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pri       <= PRI_LONGP;
         starv_cnt <= '0;
      end else if (!stall) begin
         case (pri)
            PRI_LONGP: begin
               if (starv_hit) begin
                  // Hand the next slot to the ALU and restart the count.
                  pri       <= PRI_ALU;
                  starv_cnt <= '0;
               end else if (alu_fire || !alu_valid) begin
                  starv_cnt <= '0;
               end else if (starv_cnt != STARV_LIM) begin
                  starv_cnt <= starv_cnt + 1'b1;
               end
            end
            PRI_ALU: begin
               // The forced slot is used by an ALU fire or forfeited when the
               // ALU withdraws; either way the long pipe regains priority.
               if (alu_fire || !alu_valid) begin
                  pri <= PRI_LONGP;
               end
               starv_cnt <= '0;
            end
            default: begin
               pri       <= PRI_LONGP;
               starv_cnt <= '0;
            end
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Regfile write port: one register stage after the fire. x0 writes still
   // complete the handshake but never raise the enable. Data and index hold
   // across idle cycles so the port does not toggle needlessly.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_ena   <= 1'b0;
         rf_wdat  <= '0;
         rf_rdidx <= '0;
      end else begin
         rf_ena <= any_fire & (sel_rdidx != IDX_ZERO);
         if (any_fire) begin
            rf_wdat  <= sel_wdat;
            rf_rdidx <= sel_rdidx;
         end
      end
   end

   assign wbck.rf_wbck_o_ena   = rf_ena;
   assign wbck.rf_wbck_o_wdat  = rf_wdat;
   assign wbck.rf_wbck_o_rdidx = rf_rdidx;

`ifdef E203_WBCK_SCHED_PERF_EN
   //---------------------------------------------------------------------------
   // Perf counters. Both saturate at all-ones; clear has priority over a
   // same-cycle increment. A forced grant is an ALU fire taken in PRI_ALU.
   //---------------------------------------------------------------------------
   logic [PERF_W-1:0] perf_conflict;
   logic [PERF_W-1:0] perf_starv;
   logic              conflict_evt;
   logic              forced_evt;

   assign conflict_evt = alu_valid & longp_valid & ~stall;
   assign forced_evt   = alu_fire & (pri == PRI_ALU);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflict <= '0;
         perf_starv    <= '0;
      end else if (wbck.perf_clr_i) begin
         perf_conflict <= '0;
         perf_starv    <= '0;
      end else begin
         if (conflict_evt && !(&perf_conflict)) begin
            perf_conflict <= perf_conflict + 1'b1;
         end
         if (forced_evt && !(&perf_starv)) begin
            perf_starv <= perf_starv + 1'b1;
         end
      end
   end

   assign wbck.perf_conflict_o = perf_conflict;
   assign wbck.perf_starv_o    = perf_starv;
`endif

endmodule : e203_exu_wbck_sched
`default_nettype wire
